snoop_writer: RTL and testbench

SNOOP_WRITER -- requirements
Module: snoop_writer

---
 rtl/snoop_writer.sv | 151 +++++++++++++++
 tb/tb_snoop_writer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/snoop_writer.sv
// Stream-to-packet-buffer writer: stores each beat as two 32-bit words and drops overflow beats.
// Optional macro SNOOP_BACKPRESSURE_EN holds off the stream while no buffer is attached.
module snoop_writer #(
  parameter int ADDR_WIDTH   = 10,
  parameter int SN_FWD_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SN_FWD_WIDTH-1:0]   s_tdata,
  input  logic [SN_FWD_WIDTH/8-1:0] s_tkeep,
  input  logic                      s_tvalid,
  input  logic                      s_tlast,
  output logic                      s_tready,
  input  logic                      buf_rdy,
  output logic                      wr_en,
  output logic [ADDR_WIDTH-1:0]     addr,
  output logic [SN_FWD_WIDTH-1:0]   idata,
  output logic [8:0]                byte_inc,
  output logic                      buf_done,
  output logic                      truncated
);

  typedef enum logic [1:0] {IDLE, WRITE, DROP, DONE} state_e;

  localparam logic [ADDR_WIDTH-1:0] LastSlot = {{(ADDR_WIDTH-1){1'b1}}, 1'b0};

  state_e                    state_q, state_d;
  logic [ADDR_WIDTH-1:0]     wordCnt_q, wordCnt_d;
  logic                      skipPkt_q, skipPkt_d;
  logic                      dropped_q, dropped_d;
  logic                      wrEn_q, wrEn_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [SN_FWD_WIDTH-1:0]   idata_q, idata_d;
  logic [8:0]                byteInc_q, byteInc_d;
  logic                      bufDone_q, bufDone_d;
  logic                      truncated_q, truncated_d;
  logic                      readyState;
  logic                      accept;
  logic                      capture;

  function automatic logic [8:0] popCount(input logic [SN_FWD_WIDTH/8-1:0] keep);
    logic [8:0] total;
    total = '0;
    for (int i = 0; i < SN_FWD_WIDTH/8; i++) total = total + 9'(keep[i]);
    return total;
  endfunction

  always_comb begin
    readyState = 1'b0;
    case (state_q)
`ifdef SNOOP_BACKPRESSURE_EN
      IDLE:        readyState = 1'b0;
`else
      IDLE:        readyState = 1'b1;
`endif
      WRITE, DROP: readyState = 1'b1;
      default:     readyState = 1'b0;
    endcase
  end

  assign s_tready = readyState & ~rst;
  assign accept   = s_tvalid & readyState;
  // A beat arriving in IDLE at a packet boundary with a buffer ready opens the packet itself.
  assign capture  = accept & ((state_q == WRITE) |
                              ((state_q == IDLE) & ~skipPkt_q & buf_rdy));

  always_comb begin
    state_d     = state_q;
    wordCnt_d   = wordCnt_q;
    skipPkt_d   = skipPkt_q;
    dropped_d   = dropped_q;
    wrEn_d      = 1'b0;
    addr_d      = addr_q;
    idata_d     = idata_q;
    byteInc_d   = byteInc_q;
    bufDone_d   = 1'b0;
    truncated_d = 1'b0;

    case (state_q)
      IDLE: begin
        wordCnt_d = '0;
        dropped_d = 1'b0;
        if (accept && !capture) skipPkt_d = ~s_tlast;
        else if (buf_rdy && !skipPkt_q) state_d = WRITE;
      end
      WRITE: ;
      DROP: begin
        if (accept && s_tlast) state_d = DONE;
      end
      DONE: begin
        bufDone_d   = 1'b1;
        truncated_d = dropped_q;
        dropped_d   = 1'b0;
        wordCnt_d   = '0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      wrEn_d    = 1'b1;
      addr_d    = wordCnt_q;
      idata_d   = s_tdata;
      byteInc_d = popCount(s_tkeep);
      // The final slot never advances, so the counter cannot wrap onto written words.
      if (wordCnt_q != LastSlot) wordCnt_d = wordCnt_q + ADDR_WIDTH'(2);
      if (s_tlast) begin
        state_d = DONE;
      end else if (wordCnt_q == LastSlot) begin
        state_d   = DROP;
        dropped_d = 1'b1;
      end else begin
        state_d = WRITE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wordCnt_q   <= '0;
      skipPkt_q   <= 1'b0;
      dropped_q   <= 1'b0;
      wrEn_q      <= 1'b0;
      addr_q      <= '0;
      idata_q     <= '0;
      byteInc_q   <= '0;
      bufDone_q   <= 1'b0;
      truncated_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wordCnt_q   <= wordCnt_d;
      skipPkt_q   <= skipPkt_d;
      dropped_q   <= dropped_d;
      wrEn_q      <= wrEn_d;
      addr_q      <= addr_d;
      idata_q     <= idata_d;
      byteInc_q   <= byteInc_d;
      bufDone_q   <= bufDone_d;
      truncated_q <= truncated_d;
    end
  end

  assign wr_en     = wrEn_q;
  assign addr      = addr_q;
  assign idata     = idata_q;
  assign byte_inc  = byteInc_q;
  assign buf_done  = bufDone_q;
  assign truncated = truncated_q;

endmodule

// File: tb/tb_snoop_writer.sv
// Directed bench for snoop_writer with a 16-word buffer (ADDR_WIDTH=4), default build.
module tb_snoop_writer;

  logic        clk;
  logic        rst;
  logic [63:0] s_tdata;
  logic [7:0]  s_tkeep;
  logic        s_tvalid;
  logic        s_tlast;
  logic        s_tready;
  logic        buf_rdy;
  logic        wr_en;
  logic [3:0]  addr;
  logic [63:0] idata;
  logic [8:0]  byte_inc;
  logic        buf_done;
  logic        truncated;

  int errorCount = 0;
  int checkCount = 0;

  logic [3:0]  addrQ[$];
  logic [8:0]  incQ[$];
  logic [63:0] dataQ[$];
  int cycleNum    = 0;
  int lastWrCycle = 0;
  int doneCycle   = 0;
  int doneCount   = 0;
  logic lastTrunc = 1'b0;

  snoop_writer #(.ADDR_WIDTH(4), .SN_FWD_WIDTH(64)) dut (
    .clk(clk), .rst(rst),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(s_tready), .buf_rdy(buf_rdy),
    .wr_en(wr_en), .addr(addr), .idata(idata), .byte_inc(byte_inc),
    .buf_done(buf_done), .truncated(truncated)
  );

  always #5 clk = ~clk;

  // Log every buffer write and completion pulse, sampled mid-cycle.
  always @(negedge clk) begin
    cycleNum++;
    if (wr_en) begin
      addrQ.push_back(addr);
      incQ.push_back(byte_inc);
      dataQ.push_back(idata);
      lastWrCycle = cycleNum;
    end
    if (buf_done) begin
      doneCount++;
      doneCycle = cycleNum;
      lastTrunc = truncated;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] getAddr(input int i);
    return (i < addrQ.size()) ? addrQ[i] : 4'bx;
  endfunction

  function automatic logic [8:0] getInc(input int i);
    return (i < incQ.size()) ? incQ[i] : 9'bx;
  endfunction

  function automatic logic [63:0] getData(input int i);
    return (i < dataQ.size()) ? dataQ[i] : 64'bx;
  endfunction

  task automatic clearLog();
    addrQ.delete();
    incQ.delete();
    dataQ.delete();
    doneCount = 0;
    lastTrunc = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Called at a falling edge; returns at the falling edge after the handshake.
  task automatic applyStimulus(input logic [63:0] d, input logic [7:0] k, input logic l);
    int n = 0;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    s_tvalid = 1'b1;
    #1;
    while (!s_tready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("readyWithinBound", 64'(s_tready), 64'd1);
    @(negedge clk);
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0;
    s_tlast = 1'b0; buf_rdy = 1'b0;
    #12;
    $display("[TB] reset state");
    checkOutput("rstWrEn", 64'(wr_en), 0);
    checkOutput("rstAddr", 64'(addr), 0);
    checkOutput("rstIdata", idata, 0);
    checkOutput("rstByteInc", 64'(byte_inc), 0);
    checkOutput("rstBufDone", 64'(buf_done), 0);
    checkOutput("rstTrunc", 64'(truncated), 0);
    checkOutput("rstReady", 64'(s_tready), 0);
    @(negedge clk);
    rst = 1'b0;
    buf_rdy = 1'b1;
    idleCycles(2);

    $display("[TB] three-beat packet");
    clearLog();
    applyStimulus(64'h1111_1111_1111_1111, 8'hFF, 1'b0);
    applyStimulus(64'h2222_2222_2222_2222, 8'hFF, 1'b0);
    applyStimulus(64'h3333_3333_3333_3333, 8'hF0, 1'b1);
    idleCycles(4);
    checkOutput("p3Writes", 64'(addrQ.size()), 3);
    checkOutput("p3Addr0", 64'(getAddr(0)), 0);
    checkOutput("p3Addr1", 64'(getAddr(1)), 2);
    checkOutput("p3Addr2", 64'(getAddr(2)), 4);
    checkOutput("p3Inc0", 64'(getInc(0)), 8);
    checkOutput("p3Inc2", 64'(getInc(2)), 4);
    checkOutput("p3Data0", getData(0), 64'h1111_1111_1111_1111);
    checkOutput("p3Data2", getData(2), 64'h3333_3333_3333_3333);
    checkOutput("p3Done", 64'(doneCount), 1);
    checkOutput("p3DoneGap", 64'(doneCycle - lastWrCycle), 1);
    checkOutput("p3Trunc", 64'(lastTrunc), 0);

    $display("[TB] stalled packet, buffer ready dropped mid-packet");
    clearLog();
    applyStimulus(64'hAAAA_0000_AAAA_0000, 8'hFF, 1'b0);
    buf_rdy = 1'b0;
    idleCycles(2);
    applyStimulus(64'hBBBB_0000_BBBB_0000, 8'hFC, 1'b1);
    idleCycles(4);
    checkOutput("stallWrites", 64'(addrQ.size()), 2);
    checkOutput("stallAddr0", 64'(getAddr(0)), 0);
    checkOutput("stallAddr1", 64'(getAddr(1)), 2);
    checkOutput("stallInc1", 64'(getInc(1)), 6);
    checkOutput("stallDone", 64'(doneCount), 1);

    $display("[TB] overflow packet");
    buf_rdy = 1'b1;
    idleCycles(1);
    clearLog();
    for (int i = 0; i < 10; i++) applyStimulus(64'(i), 8'hFF, (i == 9));
    idleCycles(4);
    checkOutput("ovfWrites", 64'(addrQ.size()), 8);
    checkOutput("ovfAddr0", 64'(getAddr(0)), 0);
    checkOutput("ovfAddr7", 64'(getAddr(7)), 14);
    checkOutput("ovfData7", getData(7), 64'd7);
    checkOutput("ovfDone", 64'(doneCount), 1);
    checkOutput("ovfTrunc", 64'(lastTrunc), 1);

    $display("[TB] single-beat packet");
    clearLog();
    applyStimulus(64'hDEAD_BEEF_0000_0001, 8'h80, 1'b1);
    buf_rdy = 1'b0;
    idleCycles(4);
    checkOutput("oneWrites", 64'(addrQ.size()), 1);
    checkOutput("oneAddr", 64'(getAddr(0)), 0);
    checkOutput("oneInc", 64'(getInc(0)), 1);
    checkOutput("oneDone", 64'(doneCount), 1);
    checkOutput("oneDoneGap", 64'(doneCycle - lastWrCycle), 1);
    checkOutput("oneTrunc", 64'(lastTrunc), 0);

    $display("[TB] no buffer: packets discarded");
    clearLog();
    applyStimulus(64'h5, 8'hFF, 1'b0);
    applyStimulus(64'h6, 8'hFF, 1'b0);
    applyStimulus(64'h7, 8'hFF, 1'b1);
    idleCycles(3);
    checkOutput("noBufWrites", 64'(addrQ.size()), 0);
    checkOutput("noBufDone", 64'(doneCount), 0);
    applyStimulus(64'h8, 8'hFF, 1'b0);
    buf_rdy = 1'b1;
    applyStimulus(64'h9, 8'hFF, 1'b0);
    applyStimulus(64'hA, 8'hFF, 1'b1);
    idleCycles(3);
    checkOutput("skipWrites", 64'(addrQ.size()), 0);
    checkOutput("skipDone", 64'(doneCount), 0);
    applyStimulus(64'h77, 8'hFF, 1'b1);
    idleCycles(4);
    checkOutput("afterSkipWrites", 64'(addrQ.size()), 1);
    checkOutput("afterSkipData", getData(0), 64'h77);
    checkOutput("afterSkipDone", 64'(doneCount), 1);

    $display("[TB] reset mid-packet");
    clearLog();
    applyStimulus(64'hC1, 8'hFF, 1'b0);
    applyStimulus(64'hC2, 8'hFF, 1'b0);
    #2 rst = 1'b1;
    #1;
    checkOutput("midRstWrEn", 64'(wr_en), 0);
    checkOutput("midRstAddr", 64'(addr), 0);
    checkOutput("midRstIdata", idata, 0);
    checkOutput("midRstInc", 64'(byte_inc), 0);
    checkOutput("midRstReady", 64'(s_tready), 0);
    @(negedge clk);
    rst = 1'b0;
    idleCycles(3);
    checkOutput("midRstPreWrites", 64'(addrQ.size()), 2);
    checkOutput("midRstNoDone", 64'(doneCount), 0);
    clearLog();
    applyStimulus(64'hD1, 8'hFF, 1'b0);
    applyStimulus(64'hD2, 8'hFF, 1'b1);
    idleCycles(4);
    checkOutput("postRstAddr0", 64'(getAddr(0)), 0);
    checkOutput("postRstAddr1", 64'(getAddr(1)), 2);
    checkOutput("postRstDone", 64'(doneCount), 1);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
